coef_fetch_fsm_flex: RTL

Controls the coefficient SP-SRAM in the Flex FIR datapath: it tracks update mode and runs a read burst of all coefficient taps on every sample strobe. It sits directly upstream of the SRAM access multiplexer. It drives the state code that selects host or FSM access, plus the FSM-side chip-select, write-enable and address. It also forwards the SRAM read data, with a valid flag and tap index, to the downstream MAC stage.

---
 rtl/coef_fetch_fsm_flex.sv | 78 +++++++
 1 files changed

// File: rtl/coef_fetch_fsm_flex.sv
// coef_fetch_fsm_flex: coefficient SRAM burst-read controller with an update-mode hand-off; SAMPLE_PEND_EN enables a one-deep strobe pending flag
module coef_fetch_fsm_flex #(
  parameter int P_TAP_NUM = 16
) (
  input  logic        iClk12M,
  input  logic        iRst,
  input  logic        iUpdateFlag,
  input  logic        iEnSample,
  input  logic [15:0] iRdDt,
  output logic [1:0]  oCurState,
  output logic        oCsn_Fsm,
  output logic        oWrn_Fsm,
  output logic [3:0]  oAddr_Fsm,
  output logic [15:0] oCoeff,
  output logic        oCoeffValid,
  output logic [3:0]  oCoeffIdx,
  output logic        oCoeffLast,
  output logic        oBusy
);
  typedef enum logic [1:0] {IDLE = 2'b00, UPDATE = 2'b01, MEMRD = 2'b10, DRAIN = 2'b11} state_t;
  localparam logic [3:0] LAST = 4'(P_TAP_NUM - 1);
  state_t     state_q;
  logic [3:0] cnt_q, idx_q;
  logic       csn_q, valid_q, last_q, start;
`ifdef SAMPLE_PEND_EN
  logic pend_q;
  assign start = iEnSample | pend_q;
  // an update request in Idle defers the pending burst rather than consuming it
  always_ff @(posedge iClk12M) begin
    if (iRst) pend_q <= 1'b0;
    else if (state_q == IDLE && !iUpdateFlag) pend_q <= 1'b0;
    else if (state_q[1] && iEnSample) pend_q <= 1'b1;
  end
`else
  assign start = iEnSample;
`endif
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csn_q   <= 1'b1;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= ~csn_q;
      idx_q   <= cnt_q;
      last_q  <= ~csn_q && cnt_q == LAST;
      case (state_q)
        IDLE: begin
          if (iUpdateFlag) state_q <= UPDATE;
          else if (start) begin
            state_q <= MEMRD;
            csn_q   <= 1'b0;
          end
        end
        UPDATE: if (!iUpdateFlag) state_q <= IDLE;
        MEMRD: begin
          if (cnt_q == LAST) begin
            state_q <= DRAIN;
            csn_q   <= 1'b1;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 4'd1;
        end
        DRAIN: state_q <= IDLE;
      endcase
    end
  end
  assign oCurState   = state_q;
  assign oCsn_Fsm    = csn_q;
  assign oWrn_Fsm    = 1'b1;
  assign oAddr_Fsm   = cnt_q;
  assign oCoeff      = iRdDt;
  assign oCoeffValid = valid_q;
  assign oCoeffIdx   = idx_q;
  assign oCoeffLast  = last_q;
  assign oBusy       = state_q[1];
endmodule
